// File: rtl/voice_env_mixer.sv
// rtl/voice_env_mixer.sv - four-voice square-wave mixer producing one 8-bit sample per 4-slot frame
// Define VOICE_ENV_EN to enable the per-voice decaying envelope and its prescaler.
module voice_env_mixer #(
  parameter int DIV_W       = 12,
  parameter int DECAY_SHIFT = 10,
  parameter int ENV_FLOOR   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       slot,
  input  logic [DIV_W-1:0] divider,
  output logic [7:0]       sample,
  output logic             sample_valid,
  output logic [3:0]       voice_active
);

  logic [DIV_W-1:0] last_div [4];
  logic [DIV_W-1:0] cnt      [4];
  logic [3:0]       sq;
  logic [7:0]       acc;

  logic             retrig;
  logic [DIV_W-1:0] n_div;
  logic [DIV_W-1:0] n_cnt;
  logic             n_sq;
  logic [5:0]       contrib;

`ifdef VOICE_ENV_EN
  logic [5:0]             env   [4];
  logic [DECAY_SHIFT-1:0] presc [4];
  logic [5:0]             n_env;
  logic [DECAY_SHIFT-1:0] n_presc;
`endif

  assign retrig = (divider != last_div[slot]);

  // Next state of the voice addressed by slot; retrigger outranks silence and toggle.
  always_comb begin
    n_div = last_div[slot];
    n_cnt = cnt[slot];
    n_sq  = sq[slot];
    if (retrig) begin
      n_div = divider;
      n_cnt = '0;
      n_sq  = (divider != '0);
    end else if (divider == '0) begin
      n_cnt = '0;
      n_sq  = 1'b0;
    end else if (cnt[slot] >= divider - DIV_W'(1)) begin
      n_cnt = '0;
      n_sq  = ~sq[slot];
    end else begin
      n_cnt = cnt[slot] + DIV_W'(1);
    end
  end

`ifdef VOICE_ENV_EN
  // The prescaler only runs while the envelope is above the sustain floor.
  always_comb begin
    n_env   = env[slot];
    n_presc = presc[slot];
    if (retrig) begin
      n_presc = '0;
      n_env   = (divider != '0) ? 6'd63 : 6'd0;
    end else if ((divider != '0) && (env[slot] > 6'(ENV_FLOOR))) begin
      if (presc[slot] == '1) begin
        n_env   = env[slot] - 6'd1;
        n_presc = '0;
      end else begin
        n_presc = presc[slot] + DECAY_SHIFT'(1);
      end
    end
  end

  assign contrib = n_sq ? n_env : 6'd0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{DECAY_SHIFT[0], ENV_FLOOR[0]};
  assign contrib    = (n_sq && (n_div != '0)) ? 6'd63 : 6'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < 4; v++) begin
        last_div[v] <= '0;
        cnt[v]      <= '0;
`ifdef VOICE_ENV_EN
        env[v]      <= '0;
        presc[v]    <= '0;
`endif
      end
      sq           <= '0;
      acc          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      last_div[slot] <= n_div;
      cnt[slot]      <= n_cnt;
      sq[slot]       <= n_sq;
`ifdef VOICE_ENV_EN
      env[slot]      <= n_env;
      presc[slot]    <= n_presc;
`endif
      sample_valid   <= 1'b0;
      // Slot 0 always restarts the sum, so a misordered frame self-heals next frame.
      case (slot)
        2'd0: acc <= {2'b00, contrib};
        2'd3: begin
          sample       <= acc + {2'b00, contrib};
          sample_valid <= 1'b1;
        end
        default: acc <= acc + {2'b00, contrib};
      endcase
    end
  end

  for (genvar v = 0; v < 4; v++) begin : g_active
    assign voice_active[v] = (last_div[v] != '0);
  end

endmodule
